// File: rtl/jio_pkg.sv
// Shared encodings for the jcscpu IO-bus responder: status bit positions,
// {io_io, io_da} bus operation codes and the pending-read operation codes.
package jio_pkg;

  // Positions within the [0:7] CPU bus (bit 0 is the MSB).
  localparam int unsigned ST_RXNE = 7;
  localparam int unsigned ST_TXNF = 6;
  localparam int unsigned ST_OVF  = 5;

  typedef enum logic [1:0] {
    OP_IN_DATA  = 2'b00,
    OP_IN_ADDR  = 2'b01,
    OP_OUT_DATA = 2'b10,
    OP_OUT_ADDR = 2'b11
  } io_op_e;

  typedef enum logic [1:0] {
    RD_NONE   = 2'b00,
    RD_DATA   = 2'b01,
    RD_STATUS = 2'b10
  } rd_op_e;

endpackage

// File: rtl/jio_fifo.sv
// Synchronous FIFO with registered pointers and count; push while full is
// accepted only when a pop happens in the same cycle.
module jio_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/jio_device.sv
// IO-bus responder: OUT Addr selects, OUT Data feeds TX FIFO, IN reads RX/status.
// Define JIO_LOOPBACK_EN to route the TX FIFO head into the RX FIFO internally.
module jio_device
  import jio_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR   = 8'h03,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK_clk,
  input  logic       reset,
  input  logic       io_s,
  input  logic       io_e,
  input  logic       io_io,
  input  logic       io_da,
  input  logic [0:7] bus_in,
  output logic [0:7] bus_out,
  output logic       bus_oe,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       selected
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          r_io_s_q;
  logic          r_io_e_q;
  logic          r_selected;
  logic          r_ovf;
  rd_op_e        r_rd_op;
  rd_op_e        w_rd_op_next;
  io_op_e        w_op;
  logic          w_s_rise;
  logic          w_e_rise;
  logic          w_e_fall;
  logic          w_out_data;
  logic          w_ovf_set;
  logic          w_commit_status;
  logic          w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic          w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0]    w_tx_head, w_rx_head, w_rx_din;
  logic [CW-1:0] w_tx_count, w_rx_count;
  logic [0:7]    w_status;
  logic          w_unused_cnt;

  assign w_op     = io_op_e'({io_io, io_da});
  assign w_s_rise = io_s & ~r_io_s_q;
  assign w_e_rise = io_e & ~r_io_e_q;
  assign w_e_fall = ~io_e & r_io_e_q;

  // A full TX FIFO still accepts the byte when the sink pops in the same cycle.
  assign w_out_data      = w_s_rise & (w_op == OP_OUT_DATA) & r_selected;
  assign w_tx_push       = w_out_data & (~w_tx_full | w_tx_pop);
  assign w_ovf_set       = w_out_data & w_tx_full & ~w_tx_pop;
  assign w_rx_pop        = w_e_fall & (r_rd_op == RD_DATA) & ~w_rx_empty;
  assign w_commit_status = w_e_fall & (r_rd_op == RD_STATUS);

`ifdef JIO_LOOPBACK_EN
  logic w_unused_ext;
  assign w_tx_pop     = ~w_tx_empty & ~w_rx_full;
  assign w_rx_push    = w_tx_pop;
  assign w_rx_din     = w_tx_head;
  assign tx_valid     = 1'b0;
  assign rx_ready     = 1'b0;
  assign w_unused_ext = ^{tx_ready, rx_valid, rx_data};
`else
  assign tx_valid  = ~w_tx_empty;
  assign w_tx_pop  = tx_valid & tx_ready;
  assign rx_ready  = ~w_rx_full & ~reset;
  assign w_rx_push = rx_valid & rx_ready;
  assign w_rx_din  = rx_data;
`endif

  assign tx_data      = w_tx_head;
  assign selected     = r_selected;
  assign w_unused_cnt = ^{w_tx_count, w_rx_count};

  always_comb begin
    w_rd_op_next = r_rd_op;
    if (w_e_fall) begin
      w_rd_op_next = RD_NONE;
    end else if (w_e_rise && !io_io && r_selected) begin
      w_rd_op_next = io_da ? RD_STATUS : RD_DATA;
    end
  end

  // Strobe history reloads even in reset so a held strobe is not seen as a rise.
  always_ff @(posedge CLK_clk) begin
    r_io_s_q <= io_s;
    r_io_e_q <= io_e;
    if (reset) begin
      r_selected <= 1'b0;
      r_ovf      <= 1'b0;
      r_rd_op    <= RD_NONE;
    end else begin
      r_rd_op <= w_rd_op_next;
      if (w_s_rise && (w_op == OP_OUT_ADDR)) r_selected <= (bus_in == DEV_ADDR);
      if (w_ovf_set)            r_ovf <= 1'b1;
      else if (w_commit_status) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_status          = '0;
    w_status[ST_RXNE] = ~w_rx_empty;
    w_status[ST_TXNF] = ~w_tx_full;
    w_status[ST_OVF]  = r_ovf;
  end

  assign bus_oe = io_e & ~io_io & r_selected;

  always_comb begin
    bus_out = '0;
    if (bus_oe) begin
      if (io_da)            bus_out = w_status;
      else if (!w_rx_empty) bus_out = w_rx_head;
    end
  end

  jio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .i_clk   (CLK_clk),
    .i_rst   (reset),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_data  (bus_in),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  jio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .i_clk   (CLK_clk),
    .i_rst   (reset),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_data  (w_rx_din),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

endmodule

// File: tb/tb_jio_device.sv
// Self-checking bench for jio_device: queue-based protocol model checked every
// cycle, plus directed literal expectations for each scenario.
module tb_jio_device;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       io_s = 1'b0, io_e = 1'b0, io_io = 1'b0, io_da = 1'b0;
  logic       tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0] bus_in = 8'h00, rx_data = 8'h00;
  logic [7:0] bus_out, tx_data;
  logic       bus_oe, tx_valid, rx_ready, selected;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  jio_device #(.DEV_ADDR(8'h03), .FIFO_DEPTH(DEPTH)) dut (
    .CLK_clk  (clk),
    .reset    (reset),
    .io_s     (io_s),
    .io_e     (io_e),
    .io_io    (io_io),
    .io_da    (io_da),
    .bus_in   (bus_in),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .selected (selected)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  bit m_sel = 0, m_ovf = 0, m_sq = 0, m_eq = 0, m_live = 0;
  int m_rd = 0;  // 0 none, 1 data read pending, 2 status read pending

  always @(posedge clk) begin : model
    bit srise, erise, efall, rxp;
    if (reset) begin
      m_tx.delete();
      m_rx.delete();
      m_sel = 0; m_ovf = 0; m_rd = 0; m_live = 1;
    end else begin
      srise = io_s && !m_sq;
      erise = io_e && !m_eq;
      efall = !io_e && m_eq;
      rxp   = rx_valid && (m_rx.size() < DEPTH);
      if (tx_ready && m_tx.size() > 0) void'(m_tx.pop_front());
      if (efall && m_rd == 1 && m_rx.size() > 0) void'(m_rx.pop_front());
      if (efall && m_rd == 2) m_ovf = 0;
      if (srise && io_io && !io_da && m_sel) begin
        if (m_tx.size() < DEPTH) m_tx.push_back(bus_in);
        else m_ovf = 1;
      end
      if (rxp) m_rx.push_back(rx_data);
      if (srise && io_io && io_da) m_sel = (bus_in == 8'h03);
      if (efall) m_rd = 0;
      else if (erise && !io_io && m_sel) m_rd = io_da ? 2 : 1;
    end
    m_sq = io_s;
    m_eq = io_e;
  end

  always @(negedge clk) begin : compare
    logic [7:0] e_st, e_out;
    bit e_oe;
    if (m_live) begin
      e_st  = {5'b0, m_ovf, (m_tx.size() < DEPTH), (m_rx.size() > 0)};
      e_oe  = io_e && !io_io && m_sel;
      e_out = 8'h00;
      if (e_oe) e_out = io_da ? e_st : ((m_rx.size() > 0) ? m_rx[0] : 8'h00);
      chk("m_tx_valid", {7'b0, tx_valid}, {7'b0, m_tx.size() > 0});
      if (m_tx.size() > 0) chk("m_tx_data", tx_data, m_tx[0]);
      chk("m_rx_ready", {7'b0, rx_ready}, {7'b0, !reset && (m_rx.size() < DEPTH)});
      chk("m_selected", {7'b0, selected}, {7'b0, m_sel});
      chk("m_bus_oe", {7'b0, bus_oe}, {7'b0, e_oe});
      chk("m_bus_out", bus_out, e_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic out_op(input bit da, input logic [7:0] v, input int n);
    io_io = 1'b1; io_da = da; bus_in = v; io_s = 1'b1;
    repeat (n) step();
    io_s = 1'b0;
    step();
  endtask

  task automatic in_op(input bit da, input int n, output logic [7:0] val, output logic oe);
    io_io = 1'b0; io_da = da; io_e = 1'b1;
    #1;
    val = bus_out;
    oe  = bus_oe;
    repeat (n) step();
    io_e = 1'b0;
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] v;
    logic oe;

    // reset
    repeat (3) step();
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h00);
    chk("rst_selected", {7'b0, selected}, 8'h00);
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_bus_oe", {7'b0, bus_oe}, 8'h00);
    chk("rst_bus_out", bus_out, 8'h00);
    reset = 1'b0;
    step();
    chk("post_rst_rx_ready", {7'b0, rx_ready}, 8'h01);

    // select and write
    out_op(1'b1, 8'h03, 1);
    out_op(1'b0, 8'hA5, 2);
    chk("sel_selected", {7'b0, selected}, 8'h01);
    chk("sel_tx_valid", {7'b0, tx_valid}, 8'h01);
    chk("sel_tx_data", tx_data, 8'hA5);
    tx_ready = 1'b1; step(); tx_ready = 1'b0;
    chk("drain_tx_valid", {7'b0, tx_valid}, 8'h00);

    // wrong address
    out_op(1'b1, 8'h07, 1);
    out_op(1'b0, 8'h11, 1);
    chk("wrong_selected", {7'b0, selected}, 8'h00);
    chk("wrong_tx_valid", {7'b0, tx_valid}, 8'h00);
    in_op(1'b0, 2, v, oe);
    chk("wrong_bus_oe", {7'b0, oe}, 8'h00);
    chk("wrong_bus_out", v, 8'h00);

    // read with a 3-cycle strobe
    out_op(1'b1, 8'h03, 1);
    rx_data = 8'h3C; rx_valid = 1'b1; step(); rx_valid = 1'b0;
    io_io = 1'b0; io_da = 1'b0; io_e = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("read_bus_out", bus_out, 8'h3C);
      step();
    end
    io_e = 1'b0; step();
    in_op(1'b1, 1, v, oe);
    chk("read_status", v, 8'h02);

    // overflow
    rx_data = 8'h77; rx_valid = 1'b1; step(); rx_valid = 1'b0;
    for (int i = 0; i < 5; i++) out_op(1'b0, 8'h10 + 8'(i), 1);
    in_op(1'b1, 1, v, oe);
    chk("ovf_status", v, 8'h05);
    in_op(1'b1, 1, v, oe);
    chk("ovf_cleared_status", v, 8'h01);
    chk("ovf_tx_head", tx_data, 8'h10);
    in_op(1'b0, 1, v, oe);
    chk("ovf_rx_read", v, 8'h77);
    tx_ready = 1'b1; repeat (4) step(); tx_ready = 1'b0;
    chk("ovf_drained", {7'b0, tx_valid}, 8'h00);

    // full TX with simultaneous pop accepts the push
    for (int i = 0; i < 4; i++) out_op(1'b0, 8'h20 + 8'(i), 1);
    io_io = 1'b1; io_da = 1'b0; bus_in = 8'h24; io_s = 1'b1; tx_ready = 1'b1;
    step();
    tx_ready = 1'b0; io_s = 1'b0;
    step();
    chk("fullpop_head", tx_data, 8'h21);
    in_op(1'b1, 1, v, oe);
    chk("fullpop_status", v, 8'h00);
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("fullpop_order", tx_data, 8'h21 + 8'(k));
      step();
    end
    tx_ready = 1'b0;

    // RX wrap with interleaved reads
    for (int i = 0; i < 10; i++) begin
      rx_data = 8'hC0 + 8'(i); rx_valid = 1'b1; step(); rx_valid = 1'b0;
      if (i > 0) begin
        in_op(1'b0, 1, v, oe);
        chk("wrap_order", v, 8'hC0 + 8'(i - 1));
      end
    end
    in_op(1'b0, 1, v, oe);
    chk("wrap_last", v, 8'hC9);

    // RX fill past full
    rx_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rx_data = 8'hD0 + 8'(k);
      step();
    end
    rx_valid = 1'b0;
    chk("rxfull_ready", {7'b0, rx_ready}, 8'h00);
    for (int k = 0; k < 4; k++) begin
      in_op(1'b0, 1, v, oe);
      chk("rxfull_order", v, 8'hD0 + 8'(k));
    end
    in_op(1'b1, 1, v, oe);
    chk("rxfull_status", v, 8'h02);

    // reset in the middle of a data read
    rx_valid = 1'b1;
    rx_data = 8'hE0; step();
    rx_data = 8'hE1; step();
    rx_valid = 1'b0;
    io_io = 1'b0; io_da = 1'b0; io_e = 1'b1;
    step(); step();
    reset = 1'b1; step(); step(); reset = 1'b0;
    chk("midrst_bus_oe", {7'b0, bus_oe}, 8'h00);
    chk("midrst_selected", {7'b0, selected}, 8'h00);
    io_io = 1'b1; io_da = 1'b1; bus_in = 8'h03; io_s = 1'b1; step();
    io_s = 1'b0; step();
    rx_data = 8'hF0; rx_valid = 1'b1; step(); rx_valid = 1'b0;
    io_e = 1'b0; step();
    in_op(1'b1, 1, v, oe);
    chk("midrst_status", v, 8'h03);
    in_op(1'b0, 1, v, oe);
    chk("midrst_data", v, 8'hF0);

    repeat (2) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
